label_rr_accum: RTL and testbench

- Sequential consumer for the four 8-bit result buses (out1..out4) produced by the named/labelled-block test module.
- On a start pulse, visits each input once in round-robin order (in0..in3) and sums them.
- Presents the total on a valid/ready output port.
- Used as a downstream checker stage, so that the values resolved from named blocks reach a clocked datapath.

---
 rtl/label_rr_accum.sv | 101 ++++++++++
 tb/tb_label_rr_accum.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/label_rr_accum.sv
// Round-robin accumulator: on start, adds in0..in3 (one per cycle, sampled live)
// and presents the sum on a valid/ready output until the consumer accepts it.
module label_rr_accum #(
  parameter int WIDTH = 8,
  parameter int ACC_W = WIDTH + 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic             busy,
  output logic [1:0]       idx,
  output logic [ACC_W-1:0] acc,
  output logic             out_valid,
  input  logic             out_ready
);

  // state | meaning
  // IDLE  | waiting for start; acc holds the last sum
  // ACC   | adding in[idx] each cycle, four cycles total
  // HOLD  | sum presented on acc, waiting for out_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] operand;

  always_comb begin
    operand = in0;
    case (idx_q)
      2'd0:    operand = in0;
      2'd1:    operand = in1;
      2'd2:    operand = in2;
      default: operand = in3;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          idx_d   = 2'd0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + {{(ACC_W-WIDTH){1'b0}}, operand};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        idx_d       = 2'd0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign idx       = idx_q;
  assign acc       = acc_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_label_rr_accum.sv
// Directed bench for label_rr_accum with hand-computed expected values.
module tb_label_rr_accum;

  logic       clk = 1'b0;
  logic       resetn, start, out_ready;
  logic [7:0] in0, in1, in2, in3;
  logic       busy, out_valid;
  logic [1:0] idx;
  logic [9:0] acc;

  int errors = 0;
  int checks = 0;

  label_rr_accum #(.WIDTH(8), .ACC_W(10)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .busy      (busy),
    .idx       (idx),
    .acc       (acc),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] a, b, c, d);
    in0 = a; in1 = b; in2 = c; in3 = d;
  endtask

  initial begin
    int exp_acc [4];
    exp_acc = '{10'd1, 10'd3, 10'd6, 10'd10};

    resetn = 1'b0; start = 1'b0; out_ready = 1'b0;
    set_in(8'd0, 8'd0, 8'd0, 8'd0);
    tick(); tick();
    chk("rst_acc", acc, 0);
    chk("rst_idx", idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    resetn = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // basic pass
    set_in(8'd1, 8'd2, 8'd3, 8'd4);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("basic_e0_busy", busy, 1);
    chk("basic_e0_acc", acc, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("basic_idx%0d", k), idx, k);
      chk($sformatf("basic_valid_pre%0d", k), out_valid, 0);
      tick();
      chk($sformatf("basic_acc%0d", k), acc, exp_acc[k]);
    end
    chk("basic_valid", out_valid, 1);
    chk("basic_busy_hold", busy, 1);
    chk("basic_idx_wrap", idx, 0);
    tick();
    chk("basic_accept_valid", out_valid, 0);
    chk("basic_accept_busy", busy, 0);
    chk("basic_accept_acc", acc, 10);
    tick();
    chk("basic_idle_acc", acc, 10);
    chk("basic_idle_busy", busy, 0);

    // max values
    set_in(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("max_acc", acc, 10'h3FC);
    chk("max_valid", out_valid, 1);
    tick();
    chk("max_accept", out_valid, 0);

    // backpressure with start pulses during HOLD
    set_in(8'd1, 8'd2, 8'd3, 8'd4);
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    for (int k = 0; k < 5; k++) begin
      start = (k % 2 == 0);
      tick();
      chk($sformatf("bp_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_acc%0d", k), acc, 10);
      chk($sformatf("bp_busy%0d", k), busy, 1);
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_busy", busy, 0);
    tick();
    chk("bp_no_queue_busy", busy, 0);
    chk("bp_no_queue_acc", acc, 10);

    // live sampling: in2 changes before its add edge
    set_in(8'd1, 8'd2, 8'd3, 8'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    in2 = 8'd7;
    tick(); tick();
    chk("live_acc", acc, 14);
    chk("live_valid", out_valid, 1);
    tick();
    chk("live_accept", busy, 0);

    // reset mid-ACC
    set_in(8'd1, 8'd2, 8'd3, 8'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_partial", acc, 1);
    resetn = 1'b0;
    tick();
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_idx", idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    resetn = 1'b1;
    tick();
    chk("mid_idle_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_clean_acc", acc, 10);
    tick();
    chk("mid_clean_accept", out_valid, 0);

    // back-to-back with start held
    set_in(8'd1, 8'd2, 8'd3, 8'd4);
    start = 1'b1;
    for (int p = 0; p < 2; p++) begin
      tick();
      chk($sformatf("b2b_accept_busy%0d", p), busy, 1);
      chk($sformatf("b2b_accept_acc%0d", p), acc, 0);
      tick(); tick(); tick(); tick();
      chk($sformatf("b2b_sum%0d", p), acc, 10);
      chk($sformatf("b2b_valid%0d", p), out_valid, 1);
      tick();
      chk($sformatf("b2b_hs_busy%0d", p), busy, 0);
      chk($sformatf("b2b_hs_acc%0d", p), acc, 10);
    end
    start = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
